quad_pwm_mixer: RTL and testbench
=================================

// Module: quad_pwm_mixer
// PURPOSE
//   N-channel successor to the fixed 3-channel RGB encoder driver. Each channel
//   takes a quadrature encoder pair (A/B) and runs a saturating duty register.
//   Each channel also has a PWM output generated from a shared prescaled
//   period counter.
//   Duty width, channel count, step size, synchroniser depth and PWM rate are
//   parametrised. The block adds glitch-free period-aligned duty updates,
//   illegal-transition flags and duty readback.
// PARAMETERS
//   NUM_CH      3  number of encoder/PWM channels (>=1)
//   DUTY_W      8  duty/period counter width; period = 2**DUTY_W ticks
//   STEP        1  duty change per valid quadrature transition (1..2**DUTY_W-1)
//   SYNC_STAGES 2  flops in each enc_a/enc_b synchroniser chain (>=2)
//   PRESCALE    1  clk cycles per PWM tick (>=1)
// PORTS
//   clk         in   1              system clock, rising edge
//   rst         in   1              asynchronous reset, active-low
//   enable      in   1              1 = PWM running; 0 = outputs held low
//   enc_a       in   NUM_CH         encoder phase A per channel (async)
//   enc_b       in   NUM_CH         encoder phase B per channel (async)
//   pwm_out     out  NUM_CH         registered PWM output per channel
//   duty_out    out  NUM_CH*DUTY_W  active duty per channel, ch0 in LSBs
//   enc_err     out  NUM_CH         1-cycle pulse on illegal transition
//   period_start out 1              1-cycle pulse when tick counter wraps to 0
// BEHAVIOUR
//   Reset (rst=0, async, no clock needed): all sync flops, prev-state regs,
//     raw and active duty, prescaler and tick counter go to 0. pwm_out,
//     duty_out, enc_err and period_start are 0. Release is synchronous to clk.
//   Decode (per channel, x4): s={a_sync,b_sync}, p = previous s.
//     +STEP: 00->10->11->01->00 (A leads B).
//     -STEP: 00->01->11->10->00 (B leads A).
//     s==p: no change.
//     Both bits changed: no count change, and enc_err pulses 1 cycle; p := s.
//   Timing: the raw duty updates on the SYNC_STAGES-th rising edge after the
//     input change is first sampled.
//   Arithmetic: compute in DUTY_W+1 bits, then saturate to [0, 2**DUTY_W-1].
//     There is no wrap-around. A step past a limit clamps to that limit.
//   Prescaler: counts 0..PRESCALE-1 while enable=1. The tick counter advances
//     by one when the prescaler is at PRESCALE-1.
//   Tick counter: wraps 2**DUTY_W-1 -> 0.
//   period_start pulses 1 cycle when the tick counter becomes 0 through a
//     wrap. It also pulses on the first tick after enable rises.
//   Shadowing: active duty := raw duty only at wrap-to-0 (or while enable=0),
//     so a period never sees a mid-period duty change. duty_out shows the
//     active duty.
//   PWM: pwm_out[i] registered = enable && (tick < active_duty[i]).
//     Duty 0 gives a constant 0. Duty D gives D high ticks out of 2**DUTY_W.
//     Full scale is therefore never 100%.
//   enable=0: prescaler and tick counter are held at 0, and pwm_out goes to 0
//     on the next edge. Encoders keep tracking.
//     On enable rising, the period starts at tick 0 with the current raw duty.
//   Channels are fully independent. Simultaneous transitions on all channels
//     are all counted in the same cycle.
//   Reset asserted mid-period: outputs go to 0 immediately and all duty is
//     lost.
// TESTING (defaults unless noted)
//   1 Reset, enable=1. Ch0 gets 25 cycles of A-rise,B-rise,A-fall,B-fall
//     (10 clk apart) -> duty_out ch0=100, enc_err=0.
//   2 Ch1 gets 64 such cycles, ch2 gets 80 -> both saturate at 255, no wrap to
//     0. Then 20/30/10 reverse cycles (B first) on ch0/1/2 -> duty 20/135/215.
//   3 Ch0 duty=64, PRESCALE=1 -> pwm_out[0] high exactly 64 of every 256 clk.
//     Repeat with PRESCALE=4 -> 256 high of every 1024 clk. period_start pulses
//     every 256 (resp. 1024) clk.
//   4 Change duty mid-period -> pwm_out waveform changes only after the next
//     period_start. Duty 0 -> pwm_out never high.
//   5 Toggle enc_a and enc_b in the same cycle -> enc_err pulses 1 cycle and
//     duty is unchanged. Toggle all channels at once -> all update together.
//   6 Drop rst mid-period with nonzero duty -> all outputs 0 with no clock edge
//     needed. Drop enable -> pwm_out 0 next edge while encoder still counts.

Source files
------------

// File: rtl/quad_pwm_mixer.sv
// quad_pwm_mixer: per-channel quadrature-encoder duty trackers driving PWM outputs
// from one shared prescaled period counter, with period-aligned (shadowed) duty updates.
module quad_pwm_mixer #(
  parameter int NUM_CH      = 3,
  parameter int DUTY_W      = 8,
  parameter int STEP        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        enc_a,
  input  logic [NUM_CH-1:0]        enc_b,
  output logic [NUM_CH-1:0]        pwm_out,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic [NUM_CH-1:0]        enc_err,
  output logic                     period_start
);

  localparam int               PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DUTY_W:0]  DUTY_MAX  = {1'b0, {DUTY_W{1'b1}}};
  localparam logic [DUTY_W:0]  STEP_X    = (DUTY_W+1)'(STEP);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] TICK_LAST = {DUTY_W{1'b1}};

  localparam logic [1:0] DEC_NONE = 2'b00;
  localparam logic [1:0] DEC_UP   = 2'b01;
  localparam logic [1:0] DEC_DN   = 2'b10;
  localparam logic [1:0] DEC_ERR  = 2'b11;

  // {a,b} pairs: prev -> cur classified as forward, reverse, double-bit jump or idle
  function automatic logic [1:0] quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] code;
    case ({prev, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: code = DEC_UP;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: code = DEC_DN;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: code = DEC_ERR;
      default:                            code = DEC_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] duty,
                                                  input logic up, input logic dn);
    logic [DUTY_W:0] wide;
    wide = {1'b0, duty};
    if (up) begin
      wide = wide + STEP_X;
      if (wide > DUTY_MAX) begin
        wide = DUTY_MAX;
      end else begin
        wide = wide;
      end
    end else if (dn) begin
      if (wide < STEP_X) begin
        wide = '0;
      end else begin
        wide = wide - STEP_X;
      end
    end else begin
      wide = wide;
    end
    return wide[DUTY_W-1:0];
  endfunction

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] a_sync_r;
  logic [NUM_CH-1:0][SYNC_STAGES-1:0] b_sync_r;
  logic [NUM_CH-1:0][DUTY_W-1:0]      raw_r;
  logic [NUM_CH-1:0][DUTY_W-1:0]      raw_next_s;
  logic [NUM_CH-1:0][DUTY_W-1:0]      active_r;
  logic [NUM_CH-1:0][1:0]             dec_s;
  logic [NUM_CH-1:0]                  err_s;
  logic [NUM_CH-1:0]                  enc_err_r;
  logic [NUM_CH-1:0]                  pwm_r;
  logic [PS_W-1:0]                    presc_r;
  logic [DUTY_W-1:0]                  tick_r;
  logic                               enable_d_r;
  logic                               period_start_r;
  logic                               count_en_s;
  logic                               tick_adv_s;
  logic                               wrap_s;
  logic                               start_s;
  logic                               load_s;

  // Synchroniser chains; the last flop doubles as the previous-state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync_r <= '0;
      b_sync_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        a_sync_r[i] <= {a_sync_r[i][SYNC_STAGES-2:0], enc_a[i]};
        b_sync_r[i] <= {b_sync_r[i][SYNC_STAGES-2:0], enc_b[i]};
      end
    end
  end

  // Decode the transition about to enter the last stage so raw duty lands on edge SYNC_STAGES
  always_comb begin
    dec_s      = '0;
    err_s      = '0;
    raw_next_s = raw_r;
    for (int i = 0; i < NUM_CH; i++) begin
      dec_s[i]      = quad_decode({a_sync_r[i][SYNC_STAGES-1], b_sync_r[i][SYNC_STAGES-1]},
                                  {a_sync_r[i][SYNC_STAGES-2], b_sync_r[i][SYNC_STAGES-2]});
      raw_next_s[i] = sat_step(raw_r[i], dec_s[i] == DEC_UP, dec_s[i] == DEC_DN);
      err_s[i]      = (dec_s[i] == DEC_ERR);
    end
  end

  // Timebase control: the first enabled cycle only starts the period, counting begins after it
  always_comb begin
    count_en_s = enable & enable_d_r;
    tick_adv_s = count_en_s & (presc_r == PS_LAST);
    wrap_s     = tick_adv_s & (tick_r == TICK_LAST);
    start_s    = enable & ~enable_d_r;
    load_s     = ~enable | start_s | wrap_s;
  end

  // Prescaler, tick counter and period-start pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r        <= '0;
      tick_r         <= '0;
      enable_d_r     <= 1'b0;
      period_start_r <= 1'b0;
    end else begin
      enable_d_r     <= enable;
      period_start_r <= start_s | wrap_s;
      if (!count_en_s) begin
        presc_r <= '0;
        tick_r  <= '0;
      end else if (tick_adv_s) begin
        presc_r <= '0;
        tick_r  <= tick_r + DUTY_W'(1);
      end else begin
        presc_r <= presc_r + PS_W'(1);
        tick_r  <= tick_r;
      end
    end
  end

  // Raw duty, shadowed active duty, error pulses and PWM compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_r     <= '0;
      active_r  <= '0;
      enc_err_r <= '0;
      pwm_r     <= '0;
    end else begin
      raw_r     <= raw_next_s;
      enc_err_r <= err_s;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_r[i] <= count_en_s & (tick_r < active_r[i]);
      end
      if (load_s) begin
        active_r <= raw_r;
      end else begin
        active_r <= active_r;
      end
    end
  end

  assign pwm_out      = pwm_r;
  assign duty_out     = active_r;
  assign enc_err      = enc_err_r;
  assign period_start = period_start_r;

endmodule

// File: tb/tb_quad_pwm_mixer.sv
// Self-checking bench for quad_pwm_mixer: two instances (PRESCALE 1 and 4) share all inputs;
// a quadrature-step reference model with clamping predicts duty, PWM high time and error pulses.
module tb_quad_pwm_mixer;
  localparam int NUM_CH = 3;
  localparam int DUTY_W = 8;
  localparam int STEP   = 1;
  localparam int DMAX   = 255;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [NUM_CH-1:0]        enc_a;
  logic [NUM_CH-1:0]        enc_b;
  logic [NUM_CH-1:0]        pwm1, err1, pwm4, err4;
  logic [NUM_CH*DUTY_W-1:0] duty1, duty4;
  logic                     ps1, ps4;

  int checks   = 0;
  int failures = 0;
  int exp_duty [NUM_CH];
  int phase    [NUM_CH];
  int err_cnt1 [NUM_CH];
  int err_cnt4 [NUM_CH];

  quad_pwm_mixer #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .STEP(STEP), .SYNC_STAGES(2), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm1), .duty_out(duty1), .enc_err(err1), .period_start(ps1));

  quad_pwm_mixer #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .STEP(STEP), .SYNC_STAGES(2), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
    .pwm_out(pwm4), .duty_out(duty4), .enc_err(err4), .period_start(ps4));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (err1[c] === 1'b1) err_cnt1[c]++;
      if (err4[c] === 1'b1) err_cnt4[c]++;
    end
  end

  function automatic int duty_of(input logic [NUM_CH*DUTY_W-1:0] v, input int c);
    return int'(v[c*DUTY_W +: DUTY_W]);
  endfunction

  // Forward quadrature order of {a,b}: 00 -> 10 -> 11 -> 01
  function automatic logic [1:0] gray_ab(input int p);
    logic [1:0] r;
    case (p)
      0:       r = 2'b00;
      1:       r = 2'b10;
      2:       r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  function automatic int clamp_step(input int d, input int dir);
    int v;
    v = d + dir * STEP;
    if (v > DMAX) v = DMAX;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic drive_enc();
    logic [1:0] ab;
    for (int c = 0; c < NUM_CH; c++) begin
      ab = gray_ab(phase[c]);
      enc_a[c] = ab[1];
      enc_b[c] = ab[0];
    end
  endtask

  task automatic quad_step(input logic [NUM_CH-1:0] mask, input int dir, input int gap);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        phase[c]    = (phase[c] + dir + 4) % 4;
        exp_duty[c] = clamp_step(exp_duty[c], dir);
      end
    end
    drive_enc();
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic full_cycles(input logic [NUM_CH-1:0] mask, input int dir, input int n);
    repeat (4 * n) quad_step(mask, dir, 10);
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (duty_of(duty1, c) != exp_duty[c]) begin
        failures++;
        $display("FAIL %s duty1 ch%0d: got %0d expected %0d", tag, c, duty_of(duty1, c), exp_duty[c]);
      end
      checks++;
      if (duty_of(duty4, c) != exp_duty[c]) begin
        failures++;
        $display("FAIL %s duty4 ch%0d: got %0d expected %0d", tag, c, duty_of(duty4, c), exp_duty[c]);
      end
    end
  endtask

  // Disabling makes the active duty follow the raw duty, exposing it on duty_out
  task automatic check_duty(input string tag);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_model(tag);
    enable = 1'b1;
  endtask

  task automatic check_const(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic wait_pulse(input int sel, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ((sel == 1 && ps1 === 1'b1) || (sel == 4 && ps4 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL period_start_timeout dut%0d: got no pulse expected pulse within %0d cycles", sel, limit);
    end
  endtask

  // Counts pwm high samples over one full period, from one period_start pulse to the next
  task automatic measure(input int sel, input int ch, input int n, output int hi, output int len);
    bit ok;
    bit ps;
    hi  = 0;
    len = 0;
    wait_pulse(sel, 2 * n + 8, ok);
    if (ok) begin
      do begin
        @(negedge clk);
        len++;
        if ((sel == 1 && pwm1[ch] === 1'b1) || (sel == 4 && pwm4[ch] === 1'b1)) hi++;
        ps = (sel == 1) ? ps1 : ps4;
      end while (!ps && len < 2 * n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    enc_a = '0;
    enc_b = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      phase[c] = 0;
      exp_duty[c] = 0;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4} !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h expected 0", {pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4} !== '0) begin
      failures++;
      $display("FAIL reset_held: got %h expected 0", {pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4});
    end
    enable = 1'b1;
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    bit ok;
    full_cycles(3'b001, 1, 25);
    wait_pulse(1, 600, ok);
    check_const("count_up duty1 ch0", duty_of(duty1, 0), 100);
    wait_pulse(4, 2200, ok);
    check_const("count_up duty4 ch0", duty_of(duty4, 0), 100);
    check_const("count_up enc_err", err_cnt1[0] + err_cnt1[1] + err_cnt1[2] + err_cnt4[0], 0);
  endtask

  task automatic test_saturate();
    full_cycles(3'b110, 1, 64);
    full_cycles(3'b100, 1, 16);
    check_duty("saturate");
    check_const("saturate ch1", duty_of(duty1, 1), 255);
    check_const("saturate ch2", duty_of(duty1, 2), 255);
    full_cycles(3'b111, -1, 10);
    full_cycles(3'b011, -1, 10);
    full_cycles(3'b010, -1, 10);
    check_duty("reverse");
    check_const("reverse ch0", duty_of(duty1, 0), 20);
    check_const("reverse ch1", duty_of(duty1, 1), 135);
    check_const("reverse ch2", duty_of(duty1, 2), 215);
  endtask

  task automatic test_pwm();
    int hi, len, t;
    repeat (44) quad_step(3'b001, 1, 3);
    check_duty("pwm_setup");
    measure(1, 0, 256, hi, len);
    check_const("pwm ps1 period", len, 256);
    check_const("pwm dut1 ch0 high", hi, 64);
    measure(4, 0, 1024, hi, len);
    check_const("pwm ps4 period", len, 1024);
    check_const("pwm dut4 ch0 high", hi, 256);
    t = $urandom_range(1, 250);
    while (exp_duty[1] != t) quad_step(3'b010, (t > exp_duty[1]) ? 1 : -1, 3);
    check_duty("pwm_rand_setup");
    measure(1, 1, 256, hi, len);
    check_const("pwm dut1 ch1 rand high", hi, t);
    measure(4, 1, 1024, hi, len);
    check_const("pwm dut4 ch1 rand high", hi, 4 * t);
  endtask

  task automatic test_shadow();
    bit ok;
    int d0, d1, hi_a, hi_b, len, k, dir;
    d0 = exp_duty[0];
    wait_pulse(1, 600, ok);
    hi_a = 0;
    fork
      begin
        repeat (256) begin
          @(negedge clk);
          if (pwm1[0] === 1'b1) hi_a++;
        end
      end
      begin
        repeat (20) @(negedge clk);
        k   = $urandom_range(10, 30);
        dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
        repeat (k) quad_step(3'b001, dir, 3);
      end
    join
    d1 = exp_duty[0];
    hi_b = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm1[0] === 1'b1) hi_b++;
    end
    check_const("shadow old period high", hi_a, d0);
    check_const("shadow new period high", hi_b, d1);
    repeat (d1 + 5) quad_step(3'b001, -1, 2);
    measure(1, 0, 256, hi_b, len);
    check_const("duty0 pwm high", hi_b, 0);
    check_duty("duty0");
  endtask

  task automatic test_enc_err();
    int c, dir;
    int b1 [NUM_CH];
    int b4 [NUM_CH];
    b1 = err_cnt1;
    b4 = err_cnt4;
    c = $urandom_range(0, NUM_CH - 1);
    @(negedge clk);
    phase[c] = (phase[c] + 2) % 4;
    drive_enc();
    repeat (6) @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      check_const($sformatf("enc_err pulses dut1 ch%0d", k), err_cnt1[k] - b1[k], (k == c) ? 1 : 0);
      check_const($sformatf("enc_err pulses dut4 ch%0d", k), err_cnt4[k] - b4[k], (k == c) ? 1 : 0);
    end
    check_duty("enc_err_no_change");
    b1 = err_cnt1;
    repeat (8) quad_step(3'b111, ($urandom_range(0, 1) == 1) ? 1 : -1, 3);
    check_duty("all_ch_random");
    dir = (exp_duty[0] == DMAX || exp_duty[1] == DMAX || exp_duty[2] == DMAX) ? -1 : 1;
    @(negedge clk);
    enable = 1'b0;
    quad_step(3'b111, dir, 1);
    repeat (3) @(negedge clk);
    check_model("all_ch_same_cycle");
    enable = 1'b1;
    check_const("all_ch no enc_err", err_cnt1[0] + err_cnt1[1] + err_cnt1[2] - b1[0] - b1[1] - b1[2], 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      quad_step(NUM_CH'($urandom_range(1, 7)), ($urandom_range(0, 1) == 1) ? 1 : -1, $urandom_range(2, 5));
    end
    check_duty("random");
  endtask

  task automatic test_reset_mid();
    bit ok;
    repeat (20) quad_step(3'b001, 1, 3);
    check_duty("reset_mid_setup");
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (pwm1[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_const("reset_mid pwm was high", int'(ok), 1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h expected 0", {pwm1, err1, duty1, ps1, pwm4, err4, duty4, ps4});
    end
    enc_a = '0;
    enc_b = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      phase[c] = 0;
      exp_duty[c] = 0;
    end
    @(negedge clk);
    rst = 1'b1;
    check_duty("after_reset");
  endtask

  task automatic test_enable_drop();
    bit ok;
    int prev;
    repeat (30) quad_step(3'b001, 1, 3);
    check_duty("enable_drop_setup");
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (pwm1[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check_const("enable_drop pwm was high", int'(ok), 1);
    enable = 1'b0;
    @(negedge clk);
    check_const("enable_drop pwm1", int'(pwm1), 0);
    check_const("enable_drop pwm4", int'(pwm4), 0);
    prev = exp_duty[0];
    quad_step(3'b001, 1, 1);
    @(negedge clk);
    check_const("disabled duty before sync", duty_of(duty1, 0), prev);
    repeat (2) @(negedge clk);
    check_const("disabled duty after sync", duty_of(duty1, 0), exp_duty[0]);
    repeat (4) quad_step(3'b001, 1, 3);
    repeat (4) @(negedge clk);
    check_model("disabled_tracking");
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_saturate();
    test_pwm();
    test_shadow();
    test_enc_err();
    test_random();
    test_reset_mid();
    test_enable_drop();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
